// File: rtl/dmem_port_arbiter.sv
// Data BRAM port arbiter: one access per cycle between the speculative
// load pipe and the committed-store drain. Stores win on same-word
// conflicts and after STARVE_LIMIT denied cycles; load data returns one
// cycle after grant carrying the load's tag.
module dmem_port_arbiter #(
  parameter int MEM_AW       = 10,
  parameter int TAG_W        = 6,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              ld_req_valid,
  output logic              ld_req_ready,
  input  logic [31:0]       ld_req_addr,
  input  logic [TAG_W-1:0]  ld_req_tag,
  output logic              ld_resp_valid,
  output logic [TAG_W-1:0]  ld_resp_tag,
  output logic [31:0]       ld_resp_data,
  input  logic              st_req_valid,
  output logic              st_req_ready,
  input  logic [31:0]       st_req_addr,
  input  logic [31:0]       st_req_wdata,
  input  logic [3:0]        st_req_be,
  output logic              st_starved,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic              infl_valid_q, infl_valid_d;
  logic [TAG_W-1:0]  infl_tag_q, infl_tag_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

  logic              ld_ok, st_ok, same_word, grant_ld, grant_st;
  logic [MEM_AW-1:0] ld_word, st_word;

  // Byte-offset and above-depth address bits are don't-care for the BRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_req_addr[31:MEM_AW+2], ld_req_addr[1:0],
                              st_req_addr[31:MEM_AW+2], st_req_addr[1:0]};

  // Grant: store wins when uncontested, starved, or hitting the load's word
  // (so a following load observes the freshly written data).
  always_comb begin
    ld_word    = ld_req_addr[MEM_AW+1:2];
    st_word    = st_req_addr[MEM_AW+1:2];
    ld_ok      = ld_req_valid & ~flush & ~rst;
    st_ok      = st_req_valid & ~rst;
    same_word  = (ld_word == st_word);
    st_starved = (starve_cnt_q == CNT_MAX);
    grant_st   = st_ok & (~ld_ok | st_starved | same_word);
    grant_ld   = ld_ok & ~grant_st;
  end

  // BRAM drive and request handshakes.
  always_comb begin
    ld_req_ready = grant_ld;
    st_req_ready = grant_st;
    mem_en       = grant_ld | grant_st;
    mem_we       = grant_st ? st_req_be : 4'b0000;
    mem_addr     = grant_st ? st_word : ld_word;
    mem_wdata    = grant_st ? st_req_wdata : 32'd0;
  end

  // Response path: fixed 1-cycle latency, flush kills the returning load.
  always_comb begin
    ld_resp_valid = infl_valid_q & ~flush & ~rst;
    ld_resp_tag   = infl_tag_q;
    ld_resp_data  = mem_rdata;
  end

  // Next-state for in-flight tracking and store starvation counter.
  always_comb begin
    infl_valid_d = grant_ld;
    infl_tag_d   = ld_req_tag;
    starve_cnt_d = starve_cnt_q;
    if (!st_req_valid || grant_st)
      starve_cnt_d = '0;
    else if (starve_cnt_q != CNT_MAX)
      starve_cnt_d = starve_cnt_q + 1'b1;
  end

  // State registers; async reset drops any in-flight load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl_valid_q <= 1'b0;
      infl_tag_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      infl_valid_q <= infl_valid_d;
      infl_tag_q   <= infl_tag_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a registered-read BRAM model.
module tb_dmem_port_arbiter;

  localparam int MEM_AW = 10;
  localparam int TAG_W  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              ld_req_valid, ld_req_ready;
  logic [31:0]       ld_req_addr;
  logic [TAG_W-1:0]  ld_req_tag;
  logic              ld_resp_valid;
  logic [TAG_W-1:0]  ld_resp_tag;
  logic [31:0]       ld_resp_data;
  logic              st_req_valid, st_req_ready;
  logic [31:0]       st_req_addr, st_req_wdata;
  logic [3:0]        st_req_be;
  logic              st_starved;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem [2**MEM_AW];

  dmem_port_arbiter #(.MEM_AW(MEM_AW), .TAG_W(TAG_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready),
    .ld_req_addr(ld_req_addr), .ld_req_tag(ld_req_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag),
    .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready),
    .st_req_addr(st_req_addr), .st_req_wdata(st_req_wdata),
    .st_req_be(st_req_be), .st_starved(st_starved),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // BRAM model: read-first, byte-masked write, contents = A5000000|index on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**MEM_AW; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_en) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then drive inputs 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; ld_req_valid = 0; st_req_valid = 0;
    ld_req_addr = 0; ld_req_tag = 0; st_req_addr = 0; st_req_wdata = 0; st_req_be = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    ld_req_valid = 1; st_req_valid = 1; st_req_be = 4'hF;
    mem_rdata = 0;
    repeat (2) cyc();
    #2;
    chk("rst_ld_ready", 32'(ld_req_ready), 0);
    chk("rst_st_ready", 32'(st_req_ready), 0);
    chk("rst_mem_en",   32'(mem_en), 0);
    chk("rst_mem_we",   32'(mem_we), 0);
    chk("rst_resp_vld", 32'(ld_resp_valid), 0);
    cyc(); rst = 0; idle();
    cyc();

    // 1. load only
    ld_req_valid = 1; ld_req_addr = 32'h10; ld_req_tag = 5; #2;
    chk("t1_ld_ready", 32'(ld_req_ready), 1);
    chk("t1_mem_en",   32'(mem_en), 1);
    chk("t1_mem_addr", 32'(mem_addr), 4);
    chk("t1_mem_we",   32'(mem_we), 0);
    cyc(); idle(); #2;
    chk("t1_resp_vld",  32'(ld_resp_valid), 1);
    chk("t1_resp_tag",  32'(ld_resp_tag), 5);
    chk("t1_resp_data", ld_resp_data, 32'hA500_0004);

    // 2. store only
    cyc();
    st_req_valid = 1; st_req_addr = 32'h20; st_req_wdata = 32'hDEAD_BEEF; st_req_be = 4'b0011; #2;
    chk("t2_st_ready",  32'(st_req_ready), 1);
    chk("t2_mem_we",    32'(mem_we), 32'b0011);
    chk("t2_mem_addr",  32'(mem_addr), 8);
    chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("t2_resp_vld",  32'(ld_resp_valid), 0);
    cyc(); idle(); #2;
    chk("t2_mem_word", mem[8], 32'hA500_BEEF);

    // 3. contention on different words: 4 load wins, then forced store
    cyc();
    ld_req_valid = 1; ld_req_addr = 32'h100; ld_req_tag = 1;
    st_req_valid = 1; st_req_addr = 32'h200; st_req_wdata = 32'h5555_AAAA; st_req_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("t3_ld_win%0d", i), {30'd0, ld_req_ready, st_req_ready}, 32'b10);
      chk($sformatf("t3_starv%0d", i), 32'(st_starved), 0);
      cyc();
    end
    #2;
    chk("t3_st_win",  {30'd0, ld_req_ready, st_req_ready}, 32'b01);
    chk("t3_starved", 32'(st_starved), 1);
    chk("t3_st_addr", 32'(mem_addr), 32'h80);
    cyc(); st_req_addr = 32'h204; #2;
    chk("t3_cnt_clr", 32'(st_starved), 0);
    chk("t3_ld_again", {30'd0, ld_req_ready, st_req_ready}, 32'b10);
    cyc(); idle();

    // 4. same word: store first, load next cycle sees new data
    cyc();
    ld_req_valid = 1; ld_req_addr = 32'h40; ld_req_tag = 9;
    st_req_valid = 1; st_req_addr = 32'h40; st_req_wdata = 32'hCAFE_F00D; st_req_be = 4'hF; #2;
    chk("t4_st_first", {30'd0, ld_req_ready, st_req_ready}, 32'b01);
    cyc(); st_req_valid = 0; #2;
    chk("t4_ld_next", {30'd0, ld_req_ready, st_req_ready}, 32'b10);
    cyc(); idle(); #2;
    chk("t4_resp_vld",  32'(ld_resp_valid), 1);
    chk("t4_resp_tag",  32'(ld_resp_tag), 9);
    chk("t4_resp_data", ld_resp_data, 32'hCAFE_F00D);

    // 5. flush the cycle after a load grant; concurrent store still written
    cyc();
    ld_req_valid = 1; ld_req_addr = 32'h10; ld_req_tag = 7; #2;
    chk("t5_ld_grant", 32'(ld_req_ready), 1);
    cyc();
    flush = 1; ld_req_addr = 32'h14;
    st_req_valid = 1; st_req_addr = 32'h30; st_req_wdata = 32'h1234_5678; st_req_be = 4'hF; #2;
    chk("t5_resp_kill", 32'(ld_resp_valid), 0);
    chk("t5_ld_block",  32'(ld_req_ready), 0);
    chk("t5_st_ready",  32'(st_req_ready), 1);
    chk("t5_mem_we",    32'(mem_we), 32'hF);
    cyc(); idle(); #2;
    chk("t5_no_resp",  32'(ld_resp_valid), 0);
    chk("t5_mem_word", mem[12], 32'h1234_5678);

    // 6. reset with a load in flight
    cyc();
    ld_req_valid = 1; ld_req_addr = 32'h10; ld_req_tag = 3; #2;
    chk("t6_ld_grant", 32'(ld_req_ready), 1);
    cyc();
    rst = 1; st_req_valid = 1; st_req_addr = 32'h50; st_req_be = 4'hF; #2;
    chk("t6_resp_drop", 32'(ld_resp_valid), 0);
    chk("t6_outs_zero", {27'd0, ld_req_ready, st_req_ready, mem_en, st_starved, |mem_we}, 0);
    cyc(); #2;
    chk("t6_still_zero", {29'd0, ld_resp_valid, mem_en, st_req_ready}, 0);
    cyc(); rst = 0; idle();
    cyc();
    ld_req_valid = 1; ld_req_addr = 32'h10; ld_req_tag = 12; #2;
    chk("t6_ld_grant2", 32'(ld_req_ready), 1);
    cyc(); idle(); #2;
    chk("t6_resp_vld",  32'(ld_resp_valid), 1);
    chk("t6_resp_tag",  32'(ld_resp_tag), 12);
    chk("t6_resp_data", ld_resp_data, 32'hA500_0004);

    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
